// File: rtl/microwave_ctrl.sv
//------------------------------------------------------------------------------
// microwave_ctrl
//
// Control FSM for a keypad microwave oven. The user keys in up to four BCD
// digits (mm:ss), commits them with enter, and starts cooking. While cooking,
// a 1 Hz tick counts the time down in BCD. Opening the door or pressing stop
// pauses the cook. When the time runs out, the controller beeps for
// BEEP_CYCLES clocks and then returns to idle.
//
// Parameters
//   BEEP_CYCLES   number of clocks beep stays high in DONE (>= 1)
//
// Ports
//   clock         single clock; all state changes on its rising edge
//   reset         synchronous, active-high reset
//   tick          one-cycle 1 Hz strobe from the prescaler
//   digit_valid   one-cycle strobe qualifying digit
//   digit[3:0]    BCD keypad digit; codes 10-15 are ignored
//   enter         one-cycle strobe committing the entered time
//   start         one-cycle strobe starting or resuming the cook
//   stop          one-cycle strobe pausing or cancelling
//   door_open     level, high while the door is open
//   time_bcd[15:0]{min_tens, min_ones, sec_tens, sec_ones}
//   state[2:0]    IDLE=0 ENTRY=1 READY=2 COOK=3 PAUSE=4 DONE=5
//   magnetron_on  high only in COOK
//   beep          high only while the DONE beep counter runs
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
//------------------------------------------------------------------------------
module microwave_ctrl #(
    parameter int unsigned BEEP_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        start,
    input  logic        stop,
    input  logic        door_open,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        magnetron_on,
    output logic        beep
);

    // Counter wide enough to hold BEEP_CYCLES itself.
    localparam int unsigned CNT_W = (BEEP_CYCLES < 2) ? 1 : $clog2(BEEP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_READY = 3'd2,
        S_COOK  = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        time_q,  time_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               mag_q;
    logic               beep_q;

    logic               digit_ok;

    //--------------------------------------------------------------------------
    // One-second BCD decrement with borrow. Seconds tens borrow to 5 so the
    // display rolls mm:00 -> (mm-1):59. A digit entered above its normal range
    // (e.g. sec_tens = 9) is not normalised; it simply counts down until it
    // is the one being borrowed from.
    //--------------------------------------------------------------------------
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] d3, d2, d1, d0;
        d3 = t[15:12];
        d2 = t[11:8];
        d1 = t[7:4];
        d0 = t[3:0];
        if (d0 != 4'd0) begin
            d0 = d0 - 4'd1;
        end else begin
            d0 = 4'd9;
            if (d1 != 4'd0) begin
                d1 = d1 - 4'd1;
            end else begin
                d1 = 4'd5;
                if (d2 != 4'd0) begin
                    d2 = d2 - 4'd1;
                end else begin
                    d2 = 4'd9;
                    d3 = d3 - 4'd1;
                end
            end
        end
        return {d3, d2, d1, d0};
    endfunction

    assign digit_ok = digit_valid && (digit <= 4'd9);

    //--------------------------------------------------------------------------
    // Next-state logic. Within each state the checks are ordered
    // stop > door_open > enter > start > digit > tick; any input a state does
    // not care about is simply not looked at.
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        time_d  = time_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (digit_ok) begin
                    time_d  = {12'h000, digit};
                    state_d = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (stop) begin
                    time_d  = 16'h0000;
                    state_d = S_IDLE;
                end else if (enter) begin
                    // A zero time is not cookable; fall back to idle.
                    state_d = (time_q != 16'h0000) ? S_READY : S_IDLE;
                end else if (digit_ok) begin
                    // Shift in from the right; the oldest digit drops off.
                    time_d = {time_q[11:0], digit};
                end
            end

            S_READY: begin
                if (stop) begin
                    time_d  = 16'h0000;
                    state_d = S_IDLE;
                end else if (start && !door_open) begin
                    state_d = S_COOK;
                end
            end

            S_COOK: begin
                if (stop || door_open) begin
                    // Pausing wins over a coincident tick: time is frozen.
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (time_q <= 16'h0001) begin
                        time_d  = 16'h0000;
                        state_d = S_DONE;
                        cnt_d   = CNT_W'(BEEP_CYCLES);
                    end else begin
                        time_d = bcd_dec(time_q);
                    end
                end
            end

            S_PAUSE: begin
                if (stop) begin
                    time_d  = 16'h0000;
                    state_d = S_IDLE;
                end else if (start && !door_open) begin
                    state_d = S_COOK;
                end
            end

            S_DONE: begin
                // The counter holds the number of beep cycles still owed,
                // including the current one; leave when the last one is spent.
                if (stop || (cnt_q <= CNT_W'(1))) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                time_d  = 16'h0000;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state so
    // they change on the same edge as the state they describe.
    //--------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: reset is synchronous; it only takes effect on a clock edge
            // and overrides every other input in that cycle.
            state_q <= S_IDLE;
            time_q  <= 16'h0000;
            cnt_q   <= '0;
            mag_q   <= 1'b0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            mag_q   <= (state_d == S_COOK);
            beep_q  <= (state_d == S_DONE);
        end
    end

    assign time_bcd     = time_q;
    assign state        = state_q;
    assign magnetron_on = mag_q;
    assign beep         = beep_q;

endmodule
